// File: rtl/systolic_out_deskew_acc_pkg.sv
// Shared types and lane-slicing helpers for the systolic output deskew/accumulate block.
package systolic_out_deskew_acc_pkg;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_RUN   = 1'b1
  } acc_state_e;

  // Bit offset of lane `lane` in a bus of `width`-bit lanes.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

  function automatic int bus_width(input int lanes, input int width);
    return lanes * width;
  endfunction

endpackage

// File: rtl/systolic_out_deskew_acc_row_delay_line.sv
// Fixed-depth register delay line with synchronous clear; DEPTH=0 is a plain wire.
module row_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_ctrl;
      assign unused_ctrl = clk ^ reset;
      assign dout        = din;
    end else begin : g_regs
      logic [WIDTH-1:0] stage [DEPTH];

      // NOTE: this storage array is cleared on reset on purpose, so no stale
      // partial vector can reach the accumulator after a mid-run reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          // NOTE: non-blocking so every stage shifts from its pre-edge value.
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/systolic_out_deskew_acc.sv
// Deskews the systolic array's staggered row outputs, accumulates aligned vectors
// across K-tiles and holds one finished result for a valid/ready consumer.
module systolic_out_deskew_acc
  import systolic_out_deskew_acc_pkg::*;
#(
  parameter int ARRAY_M      = 32,
  parameter int PE_OUT_WIDTH = 21,
  parameter int ACC_WIDTH    = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic                            in_last,
  input  logic [ARRAY_M*PE_OUT_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ARRAY_M*ACC_WIDTH-1:0]    out_data,
  output logic                            overflow,
  output logic                            busy
);

  localparam int IN_BUS  = bus_width(ARRAY_M, PE_OUT_WIDTH);
  localparam int ACC_BUS = bus_width(ARRAY_M, ACC_WIDTH);
  localparam int CNT_W   = $clog2(ARRAY_M) + 1;

  logic              al_valid;
  logic              al_last;
  logic [1:0]        al_ctl;
  logic [IN_BUS-1:0] al_data;

  // Lane m leaves the array m cycles late, so it gets m fewer registers.
  generate
    for (genvar m = 0; m < ARRAY_M; m++) begin : g_lane
      row_delay_line #(
        .WIDTH(PE_OUT_WIDTH),
        .DEPTH(ARRAY_M - 1 - m)
      ) u_lane_dly (
        .clk  (clk),
        .reset(reset),
        .din  (in_data[lane_lsb(m, PE_OUT_WIDTH) +: PE_OUT_WIDTH]),
        .dout (al_data[lane_lsb(m, PE_OUT_WIDTH) +: PE_OUT_WIDTH])
      );
    end
  endgenerate

  row_delay_line #(
    .WIDTH(2),
    .DEPTH(ARRAY_M - 1)
  ) u_ctl_dly (
    .clk  (clk),
    .reset(reset),
    .din  ({in_valid, in_valid & in_last}),
    .dout (al_ctl)
  );

  assign al_valid = al_ctl[1];
  assign al_last  = al_ctl[0];

  acc_state_e         state_q;
  acc_state_e         state_d;
  logic               push;
  logic               accept;
  logic [ACC_BUS-1:0] acc_q;
  logic [ACC_BUS-1:0] sum;
  logic [CNT_W-1:0]   inflight_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ACC_EMPTY;
    else       state_q <= state_d;
  end

  // NOTE: every output of this block is given a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    unique case (state_q)
      ACC_EMPTY: begin
        if (al_valid && !al_last) state_d = ACC_RUN;
      end
      ACC_RUN: begin
        if (al_valid && al_last) state_d = ACC_EMPTY;
      end
      default: state_d = ACC_EMPTY;
    endcase
    if (al_valid && al_last) push = 1'b1;
  end

  // A fresh accumulation starts from zero rather than the stale accumulator.
  always_comb begin
    sum = '0;
    for (int m = 0; m < ARRAY_M; m++) begin
      sum[lane_lsb(m, ACC_WIDTH) +: ACC_WIDTH] =
        ((state_q == ACC_RUN) ? acc_q[lane_lsb(m, ACC_WIDTH) +: ACC_WIDTH] : '0)
        + ACC_WIDTH'($signed(al_data[lane_lsb(m, PE_OUT_WIDTH) +: PE_OUT_WIDTH]));
    end
  end

  assign accept = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overflow   <= 1'b0;
      inflight_q <= '0;
    end else begin
      if (al_valid) acc_q <= sum;
      // Counts valid bits held in the control delay line.
      inflight_q <= inflight_q + CNT_W'(in_valid) - CNT_W'(al_valid);
      if (push && (!out_valid || accept)) begin
        out_valid <= 1'b1;
        out_data  <= sum;
      end else if (push) begin
        overflow  <= 1'b1;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (state_q != ACC_EMPTY) || (inflight_q != '0);

endmodule

// File: tb/tb_systolic_out_deskew_acc.sv
// Scoreboard bench for systolic_out_deskew_acc at ARRAY_M=4, PE_OUT_WIDTH=8, ACC_WIDTH=12.
module tb_systolic_out_deskew_acc;

  localparam int M  = 4;
  localparam int PW = 8;
  localparam int AW = 12;

  typedef logic [M-1:0][PW-1:0] lanes_t;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_last;
  logic [M*PW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [M*AW-1:0] out_data;
  logic            overflow;
  logic            busy;

  systolic_out_deskew_acc #(
    .ARRAY_M     (M),
    .PE_OUT_WIDTH(PW),
    .ACC_WIDTH   (AW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [M*AW-1:0]  exp_q[$];
  lanes_t           hist [M];
  logic signed [AW-1:0] macc [M];
  logic             mrun;
  lanes_t           zero_lanes;

  task automatic check(input string tag, input logic [M*AW-1:0] got, input logic [M*AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic lanes_t fill(input int v);
    lanes_t f;
    for (int j = 0; j < M; j++) f[j] = PW'(v);
    return f;
  endfunction

  // Reference accumulation in vector order; a last vector queues its result.
  task automatic model_step(input lanes_t lanes, input logic last);
    logic [M*AW-1:0] res;
    res = '0;
    for (int j = 0; j < M; j++) begin
      if (mrun) macc[j] = macc[j] + AW'($signed(lanes[j]));
      else      macc[j] = AW'($signed(lanes[j]));
      res[j*AW +: AW] = macc[j];
    end
    if (last) exp_q.push_back(res);
    mrun = !last;
  endtask

  // One cycle: present skewed inputs, score any handshake, advance to next negedge.
  task automatic tick(input logic v, input logic l, input lanes_t lanes, input logic rdy);
    logic [M*AW-1:0] exp_v;
    for (int i = M - 1; i > 0; i--) hist[i] = hist[i-1];
    if (v) hist[0] = lanes;
    else for (int j = 0; j < M; j++) hist[0][j] = PW'($urandom);
    in_valid  = v;
    in_last   = l;
    out_ready = rdy;
    for (int m = 0; m < M; m++) in_data[m*PW +: PW] = hist[m][m];
    if (v) model_step(lanes, l);
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_out", {{(M*AW-1){1'b0}}, out_valid}, '0);
      end else begin
        exp_v = exp_q.pop_front();
        check("out_data", out_data, exp_v);
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    repeat (n) tick(1'b0, 1'b0, zero_lanes, rdy);
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mrun  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    lanes_t t;
    clk        = 1'b0;
    in_data    = '0;
    zero_lanes = '0;
    mrun       = 1'b0;
    for (int i = 0; i < M; i++) hist[i] = '0;
    for (int j = 0; j < M; j++) macc[j] = '0;
    apply_reset();

    check("rst_out_valid", 48'(out_valid), 48'(0));
    check("rst_overflow",  48'(overflow),  48'(0));
    check("rst_busy",      48'(busy),      48'(0));
    check("rst_out_data",  out_data,       '0);

    // Single tile, lanes 1..4.
    t = {8'd4, 8'd3, 8'd2, 8'd1};
    tick(1'b1, 1'b1, t, 1'b1);
    check("t1_busy", 48'(busy), 48'(1));
    idle(2, 1'b1);
    check("t1_not_early", 48'(out_valid), 48'(0));
    idle(1, 1'b1);
    check("t1_valid", 48'(out_valid), 48'(1));
    check("t1_data", out_data, 48'h004003002001);
    idle(1, 1'b1);
    check("t1_valid_drop", 48'(out_valid), 48'(0));

    // Three tiles 10, 20, -5.
    tick(1'b1, 1'b0, fill(10), 1'b0);
    tick(1'b1, 1'b0, fill(20), 1'b0);
    tick(1'b1, 1'b1, fill(-5), 1'b0);
    check("t2_busy", 48'(busy), 48'(1));
    idle(2, 1'b0);
    check("t2_not_early", 48'(out_valid), 48'(0));
    idle(1, 1'b0);
    check("t2_valid", 48'(out_valid), 48'(1));
    check("t2_lane0", 48'(out_data[AW-1:0]), 48'h019);
    idle(1, 1'b1);
    check("t2_idle_busy", 48'(busy), 48'(0));

    // Backpressure: second result is dropped.
    tick(1'b1, 1'b1, fill(7), 1'b0);
    tick(1'b1, 1'b1, fill(9), 1'b0);
    void'(exp_q.pop_back());
    idle(4, 1'b0);
    check("t3_overflow", 48'(overflow), 48'(1));
    check("t3_valid", 48'(out_valid), 48'(1));
    check("t3_kept_lane3", 48'(out_data[3*AW +: AW]), 48'h007);
    idle(1, 1'b1);
    check("t3_overflow_sticky", 48'(overflow), 48'(1));
    check("t3_valid_drop", 48'(out_valid), 48'(0));

    apply_reset();
    check("rst2_overflow", 48'(overflow), 48'(0));

    // Second result lands on the first result's handshake.
    tick(1'b1, 1'b1, fill(3), 1'b0);
    tick(1'b1, 1'b1, fill(-6), 1'b0);
    idle(2, 1'b0);
    check("t4_valid_first", 48'(out_valid), 48'(1));
    idle(1, 1'b1);
    check("t4_valid_held", 48'(out_valid), 48'(1));
    check("t4_no_overflow", 48'(overflow), 48'(0));
    check("t4_lane0", 48'(out_data[AW-1:0]), 48'hFFA);
    idle(1, 1'b1);

    // Wrap: 17 tiles of 127.
    for (int i = 0; i < 17; i++) tick(1'b1, 1'(i == 16), fill(127), 1'b1);
    idle(3, 1'b1);
    check("t5_wrap_lane2", 48'(out_data[2*AW +: AW]), 48'h86F);
    idle(1, 1'b1);

    // Random tiles, gaps and lane values; consumer always ready.
    for (int i = 0; i < 40; i++) begin
      logic v;
      logic l;
      v = ($urandom_range(0, 2) != 0);
      l = ($urandom_range(0, 2) == 0);
      for (int j = 0; j < M; j++) t[j] = PW'($urandom);
      tick(v, l, t, 1'b1);
    end
    tick(1'b1, 1'b1, fill(-128), 1'b1);
    idle(6, 1'b1);

    // Reset mid-run discards the partial accumulation.
    tick(1'b1, 1'b0, fill(4), 1'b1);
    tick(1'b1, 1'b0, fill(4), 1'b1);
    apply_reset();
    check("t6_busy", 48'(busy), 48'(0));
    check("t6_valid", 48'(out_valid), 48'(0));
    tick(1'b1, 1'b1, fill(5), 1'b0);
    idle(3, 1'b0);
    check("t6_lane1", 48'(out_data[AW +: AW]), 48'h005);
    idle(1, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1, 1'b1);
    check("queue_drained", 48'(exp_q.size()), 48'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
